// File: rtl/pcs_gmii_pkg.sv
// Shared GMII constants and receive-checker state encoding for the PCS loopback bench.
package pcs_gmii_pkg;

   localparam logic [7:0] GMII_PREAMBLE = 8'h55;
   localparam logic [7:0] GMII_SFD      = 8'hD5;
   localparam logic [2:0] MAX_PREAMBLE  = 3'd7;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      PREAMBLE,
      DATA,
      DROP
   } rx_chk_state_t;

endpackage

// File: rtl/gmii_rx_fifo.sv
// Synchronous show-ahead byte FIFO; the head byte is visible on rd_data while not empty.
module gmii_rx_fifo #(
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          RX_CLK,
   input  logic                          mr_main_reset,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_rd;
   logic          do_wr;

   assign empty   = (count == '0);
   assign full    = (count == (AW + 1)'(FIFO_DEPTH));
   assign do_rd   = rd_en && !empty;
   // A write into a full FIFO is still accepted when the head is popped in the same cycle.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge RX_CLK) begin
      if (mr_main_reset && do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge RX_CLK) begin
      if (!mr_main_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gmii_rx_checker.sv
// GMII receive checker: validates preamble/SFD, buffers payload, reports per-frame status
// with a one-cycle done pulse and keeps saturating good/bad frame counters.
module gmii_rx_checker
   import pcs_gmii_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned LEN_W      = 16
) (
   input  logic                          RX_CLK,
   input  logic                          mr_main_reset,
   input  logic [7:0]                    RXD,
   input  logic                          RX_DV,
   input  logic                          RX_ER,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_done,
   output logic [LEN_W-1:0]              frame_len,
   output logic [7:0]                    frame_sum,
   output logic                          err_pre,
   output logic                          err_rx,
   output logic                          err_ovf,
   output logic [LEN_W-1:0]              good_frames,
   output logic [LEN_W-1:0]              bad_frames
);

   rx_chk_state_t    state;
   logic [2:0]       pre_cnt;
   logic [LEN_W-1:0] len;
   logic [7:0]       sum;
   logic             cur_pre;
   logic             cur_rx;
   logic             cur_ovf;
   logic             fifo_full;
   logic             accept;
   logic             wr_en;
   logic             frame_end;
   logic             end_pre;
   logic             end_bad;

   assign accept    = !fifo_full || rd_en;
   assign wr_en     = (state == DATA) && RX_DV && accept;
   assign frame_end = !RX_DV && (state == PREAMBLE || state == DATA || state == DROP);
   // Carrier dropping during the preamble is itself a preamble error.
   assign end_pre   = cur_pre || (state == PREAMBLE);
   assign end_bad   = end_pre || cur_rx || cur_ovf;

   gmii_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .RX_CLK        (RX_CLK),
      .mr_main_reset (mr_main_reset),
      .wr_en         (wr_en),
      .wr_data       (RXD),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .full          (fifo_full),
      .empty         (fifo_empty),
      .count         (fifo_count)
   );

   always_ff @(posedge RX_CLK) begin
      if (!mr_main_reset) begin
         state       <= WAIT_IDLE;
         pre_cnt     <= '0;
         len         <= '0;
         sum         <= '0;
         cur_pre     <= 1'b0;
         cur_rx      <= 1'b0;
         cur_ovf     <= 1'b0;
         frame_done  <= 1'b0;
         frame_len   <= '0;
         frame_sum   <= '0;
         err_pre     <= 1'b0;
         err_rx      <= 1'b0;
         err_ovf     <= 1'b0;
         good_frames <= '0;
         bad_frames  <= '0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            WAIT_IDLE: if (!RX_DV) state <= IDLE;
            IDLE: begin
               if (RX_DV) begin
                  len     <= '0;
                  sum     <= '0;
                  cur_rx  <= 1'b0;
                  cur_ovf <= 1'b0;
                  if (RXD == GMII_PREAMBLE) begin
                     state   <= PREAMBLE;
                     pre_cnt <= 3'd1;
                     cur_pre <= 1'b0;
                  end else begin
                     state   <= DROP;
                     cur_pre <= 1'b1;
                  end
               end
            end
            PREAMBLE: begin
               if (!RX_DV) begin
                  state <= IDLE;
               end else if (RXD == GMII_PREAMBLE && pre_cnt < MAX_PREAMBLE) begin
                  pre_cnt <= pre_cnt + 3'd1;
               end else if (RXD == GMII_SFD && pre_cnt != 3'd0) begin
                  state <= DATA;
                  len   <= '0;
                  sum   <= '0;
               end else begin
                  state   <= DROP;
                  cur_pre <= 1'b1;
               end
            end
            DATA: begin
               if (!RX_DV) begin
                  state <= IDLE;
               end else begin
                  if (len != '1) len <= len + 1'b1;
                  if (accept) sum <= sum + RXD;
                  else        cur_ovf <= 1'b1;
                  if (RX_ER) cur_rx <= 1'b1;
               end
            end
            DROP:    if (!RX_DV) state <= IDLE;
            default: state <= WAIT_IDLE;
         endcase

         if (frame_end) begin
            frame_done <= 1'b1;
            frame_len  <= len;
            frame_sum  <= sum;
            err_pre    <= end_pre;
            err_rx     <= cur_rx;
            err_ovf    <= cur_ovf;
            if (end_bad) begin
               if (bad_frames != '1) bad_frames <= bad_frames + 1'b1;
            end else begin
               if (good_frames != '1) good_frames <= good_frames + 1'b1;
            end
         end
      end
   end

endmodule
